encrypt_v3: RTL

- Next-generation iterative PRESENT block cipher core. Supports encryption and decryption, and 80- or 128-bit keys via a parameter.
- Uses the same 4-phase req/ack handshake as the previous generation and computes one round per clock.
- Sits between a host request interface and downstream consumers of C.
- Decryption first expands the key forward to the final round key, then runs the rounds in reverse.

---
 rtl/present_pkg.sv | 106 ++++++++++
 rtl/present_keyreg.sv | 42 ++++
 rtl/encrypt_v3.sv | 133 +++++++++++++
 3 files changed

// File: rtl/present_pkg.sv
// Shared PRESENT primitives: S-box layers, bit permutation, key schedule
// steps and the controller state encoding.
package present_pkg;

  localparam int BLK_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KEYX  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FIN   = 3'd3,
    ST_DONE  = 3'd4
  } fsm_t;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hc;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hb;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'ha;  4'h7: y = 4'hd;
      4'h8: y = 4'h3;  4'h9: y = 4'he;  4'ha: y = 4'hf;  4'hb: y = 4'h8;
      4'hc: y = 4'h4;  4'hd: y = 4'h7;  4'he: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'he;  4'h2: y = 4'hf;  4'h3: y = 4'h8;
      4'h4: y = 4'hc;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hd;
      4'h8: y = 4'hb;  4'h9: y = 4'h4;  4'ha: y = 4'h6;  4'hb: y = 4'h3;
      4'hc: y = 4'h0;  4'hd: y = 4'h7;  4'he: y = 4'h9;  default: y = 4'ha;
    endcase
    return y;
  endfunction

  function automatic logic [BLK_W-1:0] sbox_layer(input logic [BLK_W-1:0] x);
    logic [BLK_W-1:0] y;
    y = '0;
    for (int n = 0; n < 16; n++) y[4*n +: 4] = sbox(x[4*n +: 4]);
    return y;
  endfunction

  function automatic logic [BLK_W-1:0] sbox_layer_inv(input logic [BLK_W-1:0] x);
    logic [BLK_W-1:0] y;
    y = '0;
    for (int n = 0; n < 16; n++) y[4*n +: 4] = sbox_inv(x[4*n +: 4]);
    return y;
  endfunction

  // Bit j lands on (16*j) mod 63; bit 63 stays put.
  function automatic logic [BLK_W-1:0] p_layer(input logic [BLK_W-1:0] x);
    logic [BLK_W-1:0] y;
    y = '0;
    for (int j = 0; j < 63; j++) y[(16*j) % 63] = x[j];
    y[63] = x[63];
    return y;
  endfunction

  function automatic logic [BLK_W-1:0] p_layer_inv(input logic [BLK_W-1:0] x);
    logic [BLK_W-1:0] y;
    y = '0;
    for (int j = 0; j < 63; j++) y[j] = x[(16*j) % 63];
    y[63] = x[63];
    return y;
  endfunction

  // Key registers are carried zero-extended to 128 bits; k128 selects the
  // 128-bit schedule, otherwise only bits [79:0] are meaningful.
  function automatic logic [127:0] key_upd(input logic [127:0] k,
                                           input logic [4:0]   rc,
                                           input logic         k128);
    logic [127:0] r;
    if (k128) begin
      r = {k[66:0], k[127:67]};
      r[127:124] = sbox(r[127:124]);
      r[123:120] = sbox(r[123:120]);
      r[66:62]   = r[66:62] ^ rc;
    end else begin
      r = {48'd0, k[18:0], k[79:19]};
      r[79:76] = sbox(r[79:76]);
      r[19:15] = r[19:15] ^ rc;
    end
    return r;
  endfunction

  function automatic logic [127:0] key_upd_inv(input logic [127:0] k,
                                               input logic [4:0]   rc,
                                               input logic         k128);
    logic [127:0] t;
    logic [127:0] r;
    t = k;
    if (k128) begin
      t[66:62]   = t[66:62] ^ rc;
      t[127:124] = sbox_inv(t[127:124]);
      t[123:120] = sbox_inv(t[123:120]);
      r = {t[60:0], t[127:61]};
    end else begin
      t[19:15] = t[19:15] ^ rc;
      t[79:76] = sbox_inv(t[79:76]);
      r = {48'd0, t[60:0], t[79:61]};
    end
    return r;
  endfunction

endpackage

// File: rtl/present_keyreg.sv
// Round-key register. Loads the user key, steps the schedule forward or
// backward by one round, and exposes the 64 most significant key bits.
module present_keyreg
  import present_pkg::*;
#(
  parameter int KEY_W = 80
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             fwd,
  input  logic             inv,
  input  logic [4:0]       rc,
  input  logic [KEY_W-1:0] k,
  output logic [63:0]      keytop
);

  localparam logic IS_128 = (KEY_W == 128);

  logic [KEY_W-1:0] key_q;
  logic [KEY_W-1:0] key_d;

  // Next key: load has priority, then forward step, then reverse step.
  always_comb begin
    key_d = key_q;
    if (load)
      key_d = k;
    else if (fwd)
      key_d = KEY_W'(key_upd(128'(key_q), rc, IS_128));
    else if (inv)
      key_d = KEY_W'(key_upd_inv(128'(key_q), rc, IS_128));
  end

  // Key state register, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) key_q <= '0;
    else     key_q <= key_d;
  end

  assign keytop = key_q[KEY_W-1 -: 64];

endmodule

// File: rtl/encrypt_v3.sv
// Iterative PRESENT core, one round per clock, 4-phase req/ack.
// Handshake: req rising in IDLE loads the operands; ack rises when C is
// valid and stays high until req is seen low, then the core returns to IDLE.
module encrypt_v3
  import present_pkg::*;
#(
  parameter int KEY_W  = 80,
  parameter int ROUNDS = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  output logic             ack,
  input  logic             dec,
  input  logic [KEY_W-1:0] K,
  input  logic [BLK_W-1:0] M,
  output logic [BLK_W-1:0] C
);

  if (KEY_W != 80 && KEY_W != 128) begin : g_bad_key_w
    $error("encrypt_v3: KEY_W must be 80 or 128");
  end
  if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
    $error("encrypt_v3: ROUNDS must be in 1..31");
  end

  localparam logic [4:0] LAST = 5'(ROUNDS);

  fsm_t             fsm_q, fsm_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [BLK_W-1:0] c_q, c_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             ack_q, ack_d;
  logic             key_load, key_fwd, key_inv;
  logic [63:0]      keytop;

  present_keyreg #(.KEY_W(KEY_W)) u_keyreg (
    .clk    (clk),
    .rst    (rst),
    .load   (key_load),
    .fwd    (key_fwd),
    .inv    (key_inv),
    .rc     (cnt_q),
    .k      (K),
    .keytop (keytop)
  );

  // Controller: next state, datapath updates and key-schedule strobes.
  always_comb begin
    fsm_d    = fsm_q;
    blk_d    = blk_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    ack_d    = ack_q;
    key_load = 1'b0;
    key_fwd  = 1'b0;
    key_inv  = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        if (req && !ack_q) begin
          blk_d    = M;
          mode_d   = dec;
          key_load = 1'b1;
          cnt_d    = 5'd1;
          fsm_d    = dec ? ST_KEYX : ST_ROUND;
        end
      end
      ST_KEYX: begin
        // Run the schedule forward to the last round key before decrypting.
        key_fwd = 1'b1;
        if (cnt_q == LAST) begin
          cnt_d = LAST;
          fsm_d = ST_ROUND;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      ST_ROUND: begin
        if (!mode_q) begin
          blk_d   = p_layer(sbox_layer(blk_q ^ keytop));
          key_fwd = 1'b1;
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == LAST) fsm_d = ST_FIN;
        end else begin
          blk_d   = sbox_layer_inv(p_layer_inv(blk_q ^ keytop));
          key_inv = 1'b1;
          cnt_d   = cnt_q - 5'd1;
          if (cnt_q == 5'd1) fsm_d = ST_FIN;
        end
      end
      ST_FIN: begin
        c_d   = blk_q ^ keytop;
        ack_d = 1'b1;
        fsm_d = ST_DONE;
      end
      ST_DONE: begin
        if (!req) begin
          ack_d = 1'b0;
          fsm_d = ST_IDLE;
        end
      end
      default: begin
        fsm_d = ST_IDLE;
        ack_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q  <= ST_IDLE;
      blk_q  <= '0;
      c_q    <= '0;
      cnt_q  <= '0;
      mode_q <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      blk_q  <= blk_d;
      c_q    <= c_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      ack_q  <= ack_d;
    end
  end

  assign ack = ack_q;
  assign C   = c_q;

endmodule
